// File: rtl/calc_pkg.sv
// Shared definitions for the calculator input unit: key codes, BCD constants
// and the operand-entry state type.
`timescale 1ns/1ps
package calc_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_SIGN      = 4'd10;
    localparam logic [3:0] KEY_CLR       = 4'd11;
    localparam logic [3:0] KEY_BKSP      = 4'd12;
    localparam logic [3:0] KEY_ENTER     = 4'd13;

    localparam logic [3:0] BCD_MINUS     = 4'd14;
    localparam int         MAG_MAX       = 127;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CONVERT = 2'd1,
        OUTPUT  = 2'd2
    } entry_state_t;

endpackage

// File: rtl/bcd_mag_limit.sv
// Combinational range check: flags a 3-digit BCD magnitude greater than the
// largest operand magnitude the arithmetic unit accepts.
`timescale 1ns/1ps
module bcd_mag_limit
    import calc_pkg::*;
(
    input  logic [11:0] mag,
    output logic        over
);

    logic [9:0] bin;

    assign bin  = 10'(mag[11:8]) * 10'd100 + 10'(mag[7:4]) * 10'd10 + 10'(mag[3:0]);
    assign over = (bin > 10'(MAG_MAX));

endmodule

// File: rtl/operand_entry_ctrl.sv
// Keypad-to-operand sequencer: builds a signed BCD operand, converts it to
// two's complement and hands it off. Backspace key enabled by OPERAND_ENTRY_BACKSPACE_EN.
`timescale 1ns/1ps
module operand_entry_ctrl
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic              key_ready,
    output logic [15:0]       bcd_display,
    output logic              overflow_flag,
    output logic              op_valid,
    input  logic              op_ready,
    output logic signed [7:0] op_value
);

    entry_state_t state;
    logic [7:0]   acc;
    logic [1:0]   conv_step;

    logic [3:0]   sign_d, d2, d1, d0;
    logic [11:0]  cand_mag;
    logic         cand_over;
    logic         key_take;
    logic [3:0]   conv_digit;
    logic [7:0]   acc_next;

    function automatic logic signed [7:0] apply_sign(input logic [7:0] mag, input logic neg);
        // Negating zero yields zero, so a minus-zero entry collapses to 0.
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    assign {sign_d, d2, d1, d0} = bcd_display;
    assign cand_mag  = {d1, d0, key_code};
    assign key_ready = (state == ENTRY);
    assign key_take  = key_valid && key_ready;

    bcd_mag_limit u_mag_limit (
        .mag  (cand_mag),
        .over (cand_over)
    );

    always_comb begin
        conv_digit = d0;
        case (conv_step)
            2'd0:    conv_digit = d2;
            2'd1:    conv_digit = d1;
            default: conv_digit = d0;
        endcase
    end

    // Magnitude is capped at 127, so the 8-bit accumulator never wraps.
    assign acc_next = acc * 8'd10 + {4'd0, conv_digit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ENTRY;
            bcd_display   <= 16'd0;
            overflow_flag <= 1'b0;
            op_valid      <= 1'b0;
            op_value      <= 8'sd0;
            acc           <= 8'd0;
            conv_step     <= 2'd0;
        end else begin
            case (state)
                ENTRY: begin
                    if (key_take) begin
                        if (key_code <= KEY_DIGIT_MAX) begin
                            if ((d2 != 4'd0) || cand_over) begin
                                overflow_flag <= 1'b1;
                            end else begin
                                bcd_display   <= {sign_d, cand_mag};
                                overflow_flag <= 1'b0;
                            end
                        end else begin
                            case (key_code)
                                KEY_SIGN: begin
                                    bcd_display[15:12] <= (sign_d == BCD_MINUS) ? 4'd0 : BCD_MINUS;
                                    overflow_flag      <= 1'b0;
                                end
                                KEY_CLR: begin
                                    bcd_display   <= 16'd0;
                                    overflow_flag <= 1'b0;
                                end
                                KEY_BKSP: begin
`ifdef OPERAND_ENTRY_BACKSPACE_EN
                                    bcd_display   <= {sign_d, 4'd0, d2, d1};
                                    overflow_flag <= 1'b0;
`endif
                                end
                                KEY_ENTER: begin
                                    state     <= CONVERT;
                                    acc       <= 8'd0;
                                    conv_step <= 2'd0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CONVERT: begin
                    acc       <= acc_next;
                    conv_step <= conv_step + 2'd1;
                    if (conv_step == 2'd2) begin
                        state    <= OUTPUT;
                        op_valid <= 1'b1;
                        op_value <= apply_sign(acc_next, sign_d == BCD_MINUS);
                    end
                end
                OUTPUT: begin
                    if (op_ready) begin
                        op_valid    <= 1'b0;
                        bcd_display <= 16'd0;
                        state       <= ENTRY;
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule
